// File: rtl/onetofour_demux_stream.sv
// onetofour_demux_stream: registered 1:4 valid/ready demux routing BURST_LEN-beat bursts by a select latched on the first beat; per-channel delivery counters under DEMUX_CNT_EN
module onetofour_demux_stream #(
  parameter int WIDTH = 1,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic             busy,
  output logic [1:0]       ch
`ifdef DEMUX_CNT_EN
  ,
  output logic [7:0]       a_cnt,
  output logic [7:0]       b_cnt,
  output logic [7:0]       c_cnt,
  output logic [7:0]       d_cnt
`endif
);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] out_data;
  logic out_valid, sel_ready, take, acc;
  logic [3:0] rdy, vld;
  assign rdy = {d_ready, c_ready, b_ready, a_ready};
  assign sel_ready = rdy[ch];
  assign take = out_valid && sel_ready;
  assign din_ready = state != DRAIN && (!out_valid || sel_ready);
  assign acc = din_valid && din_ready;
  assign vld = out_valid ? 4'b0001 << ch : 4'b0000;
  assign {d_valid, c_valid, b_valid, a_valid} = vld;
  assign a = vld[0] ? out_data : '0;
  assign b = vld[1] ? out_data : '0;
  assign c = vld[2] ? out_data : '0;
  assign d = vld[3] ? out_data : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (acc) begin
        cnt_nxt = CW'(1);
        state_nxt = BURST_LEN == 1 ? DRAIN : BURST;
      end
      BURST: if (acc) begin
        cnt_nxt = cnt + CW'(1);
        state_nxt = cnt_nxt == CW'(BURST_LEN) ? DRAIN : BURST;
      end
      DRAIN: if (take) begin
        cnt_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      ch <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      out_valid <= acc || (out_valid && !sel_ready);
      if (acc) out_data <= din;
      if (acc && state == IDLE) ch <= {s0, s1};
    end
  end
`ifdef DEMUX_CNT_EN
  logic [3:0][7:0] dcnt;
  assign {d_cnt, c_cnt, b_cnt, a_cnt} = dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= '0;
    else for (int i = 0; i < 4; i++) if (vld[i] && rdy[i]) dcnt[i] <= dcnt[i] + 8'd1;
  end
`endif
endmodule

// File: tb/tb_onetofour_demux_stream.sv
// tb_onetofour_demux_stream: directed scenarios plus random traffic against a beat-level reference model
module tb_onetofour_demux_stream;
  localparam int W = 1, BL = 4;
  logic clk = 0, rst_n = 0;
  logic [W-1:0] din = '0;
  logic din_valid = 0, s0 = 0, s1 = 0;
  logic a_ready = 0, b_ready = 0, c_ready = 0, d_ready = 0;
  logic din_ready, a_valid, b_valid, c_valid, d_valid, busy;
  logic [W-1:0] a, b, c, d;
  logic [1:0] ch;
`ifdef DEMUX_CNT_EN
  logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif
  int checks = 0, failures = 0;
  bit pv = 0;
  logic [W-1:0] pd = '0;
  int pch = 0, bcnt = 0, bch = 0;
  int dcnt [4] = '{0, 0, 0, 0};

  onetofour_demux_stream #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .s0(s0), .s1(s1), .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
`ifdef DEMUX_CNT_EN
    .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt),
`endif
    .busy(busy), .ch(ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input bit dv, input logic [W-1:0] dd, input logic [1:0] s, input logic [3:0] r, output bit acc);
    bit exp_rdy, take;
    logic [3:0] ev;
    logic [W-1:0] outs [4];
    @(negedge clk);
    din_valid = dv; din = dd; {s0, s1} = s; {d_ready, c_ready, b_ready, a_ready} = r;
    #1;
    exp_rdy = bcnt != BL && (!pv || r[pch]);
    ev = pv ? 4'(1 << pch) : 4'b0;
    outs = '{a, b, c, d};
    chk("din_ready", 32'(din_ready), 32'(exp_rdy));
    chk("valids", 32'({d_valid, c_valid, b_valid, a_valid}), 32'(ev));
    for (int i = 0; i < 4; i++) chk($sformatf("data%0d", i), 32'(outs[i]), 32'(ev[i] ? pd : '0));
    chk("busy", 32'(busy), 32'(bcnt != 0));
    chk("ch", 32'(ch), 32'(bch));
`ifdef DEMUX_CNT_EN
    chk("a_cnt", 32'(a_cnt), 32'(dcnt[0]));
    chk("b_cnt", 32'(b_cnt), 32'(dcnt[1]));
    chk("c_cnt", 32'(c_cnt), 32'(dcnt[2]));
    chk("d_cnt", 32'(d_cnt), 32'(dcnt[3]));
`endif
    take = pv && r[pch];
    acc = dv && exp_rdy;
    @(posedge clk);
    if (take) begin
      pv = 0;
      dcnt[pch] = (dcnt[pch] + 1) % 256;
      if (bcnt == BL) bcnt = 0;
    end
    if (acc) begin
      if (bcnt == 0) bch = int'(s);
      pv = 1; pd = dd; pch = bch; bcnt++;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] dd, input logic [1:0] s, input logic [3:0] r);
    bit acc = 0;
    for (int k = 0; k < 20 && !acc; k++) step(1, dd, s, r, acc);
    chk("accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(0, '0, 2'b00, 4'hF, acc);
  endtask

  task automatic mid_reset;
    @(negedge clk);
    rst_n = 0; din_valid = 0;
    #1;
    chk("rst_valids", 32'({d_valid, c_valid, b_valid, a_valid}), 32'd0);
    chk("rst_data", 32'({a, b, c, d}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    pv = 0; bcnt = 0; bch = 0; dcnt = '{0, 0, 0, 0};
    #1;
    chk("rst_ready", 32'(din_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] pat [4];
    bit acc;
    pat = '{1, 0, 1, 1};
    mid_reset;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) send_beat(pat[k], 2'(s), 4'hF);
      idle(2);
    end
    send_beat(1, 2'b01, 4'hF);
    send_beat(0, 2'b01, 4'hF);
    send_beat(1, 2'b11, 4'hF);
    send_beat(1, 2'b11, 4'hF);
    idle(2);
    send_beat(1, 2'b01, 4'hF);
    send_beat(0, 2'b01, 4'hF);
    for (int k = 0; k < 3; k++) step(1, 1, 2'b01, 4'b1100 | 4'(k & 1), acc);
    send_beat(1, 2'b01, 4'hF);
    send_beat(0, 2'b01, 4'hF);
    idle(2);
    send_beat(1, 2'b00, 4'hF);
    send_beat(1, 2'b00, 4'hF);
    mid_reset;
    for (int k = 0; k < 4; k++) send_beat(pat[k], 2'b10, 4'hF);
    idle(2);
    for (int k = 0; k < 12; k++) send_beat(W'($urandom), 2'b10, 4'hF);
    for (int k = 0; k < 256; k++) send_beat(W'($urandom), 2'b00, 4'hF);
    idle(3);
    for (int k = 0; k < 500; k++)
      step($urandom_range(3) != 0, W'($urandom), 2'($urandom), 4'($urandom) | 4'($urandom), acc);
    idle(8);
    mid_reset;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
